// File: rtl/mvau_hls_deadlock_report_ctrl_if.sv
// Signal bundle between the deadlock report controller and its monitor/debug harness.
// No valid/ready handshake here: block_in/enable are sampled every edge, clear is a level acknowledge.
interface mvau_hls_deadlock_report_ctrl_if #(
    parameter int NUM_MON = 4,
    parameter int CNT_W   = 16,
    parameter int SRC_W   = 2
);
    logic [NUM_MON-1:0] block_in;
    logic               enable;
    logic               clear;
    logic               deadlock;
    logic [SRC_W-1:0]   deadlock_src;
    logic [CNT_W-1:0]   stall_cnt;
    logic [NUM_MON-1:0] snapshot;
    logic [1:0]         state_dbg;

    modport master (
        output block_in, enable, clear,
        input  deadlock, deadlock_src, stall_cnt, snapshot, state_dbg
    );

    modport slave (
        input  block_in, enable, clear,
        output deadlock, deadlock_src, stall_cnt, snapshot, state_dbg
    );
endinterface

// File: rtl/mvau_hls_deadlock_report_ctrl.sv
// Qualifies MVAU_hls_0 monitor block flags into a sticky deadlock report.
// Optional snapshot register enabled by macro DEADLOCK_SNAPSHOT_EN.
module mvau_hls_deadlock_report_ctrl #(
    parameter int NUM_MON = 4,
    parameter int THRESH  = 1024,
    parameter int CNT_W   = 16,
    parameter int SRC_W   = 2
) (
    input  logic clock,
    input  logic reset,
    mvau_hls_deadlock_report_ctrl_if.slave bus
);
    if (NUM_MON < 1) begin : g_bad_num_mon
        $error("NUM_MON must be at least 1");
    end
    if (SRC_W != ((NUM_MON > 1) ? $clog2(NUM_MON) : 1)) begin : g_bad_src_w
        $error("SRC_W must equal max(1, clog2(NUM_MON))");
    end
    // A threshold above the counter range would leave the count pinned at saturation forever.
    if (THRESH < 1 || THRESH > (2 ** CNT_W) - 1) begin : g_bad_thresh
        $error("THRESH must lie in 1 .. 2^CNT_W-1");
    end

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        WATCH    = 2'd1,
        DETECTED = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic               deadlock_q, deadlock_d;
    logic [SRC_W-1:0]   src_q, src_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [NUM_MON-1:0] snap_d;

    logic               any_blk;
    logic [SRC_W-1:0]   low_idx;
    logic [CNT_W:0]     cnt_plus1;
    logic [CNT_W-1:0]   cnt_sat_inc;
    logic               hit;

    assign any_blk     = |bus.block_in;
    assign cnt_plus1   = {1'b0, cnt_q} + 1'b1;
    assign cnt_sat_inc = (&cnt_q) ? cnt_q : cnt_plus1[CNT_W-1:0];
    assign hit         = (cnt_plus1 == (CNT_W+1)'(THRESH));

    always_comb begin
        low_idx = '0;
        for (int i = NUM_MON - 1; i >= 0; i--) begin
            if (bus.block_in[i]) low_idx = SRC_W'(i);
        end
    end

    always_comb begin
        state_d    = state_q;
        deadlock_d = deadlock_q;
        src_d      = src_q;
        cnt_d      = cnt_q;
        snap_d     = '0;
        if (bus.clear) begin
            // Acknowledge wins over detection and counting on the same edge.
            state_d    = IDLE;
            deadlock_d = 1'b0;
            src_d      = '0;
            cnt_d      = '0;
        end else begin
            case (state_q)
                IDLE, WATCH: begin
                    if (bus.enable && any_blk) begin
                        if (hit) begin
                            state_d    = DETECTED;
                            deadlock_d = 1'b1;
                            src_d      = low_idx;
                            cnt_d      = CNT_W'(THRESH);
                            snap_d     = bus.block_in;
                        end else begin
                            state_d = WATCH;
                            cnt_d   = (state_q == IDLE) ? CNT_W'(1) : cnt_sat_inc;
                        end
                    end else begin
                        state_d = IDLE;
                        cnt_d   = '0;
                    end
                end
                DETECTED: ;
                default: begin
                    state_d    = IDLE;
                    deadlock_d = 1'b0;
                    src_d      = '0;
                    cnt_d      = '0;
                end
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q    <= IDLE;
            deadlock_q <= 1'b0;
            src_q      <= '0;
            cnt_q      <= '0;
        end else begin
            state_q    <= state_d;
            deadlock_q <= deadlock_d;
            src_q      <= src_d;
            cnt_q      <= cnt_d;
        end
    end

`ifdef DEADLOCK_SNAPSHOT_EN
    logic [NUM_MON-1:0] snapshot_q;

    // Loads only on the detection edge, cleared by clear; frozen otherwise.
    always_ff @(posedge clock) begin
        if (reset || bus.clear) begin
            snapshot_q <= '0;
        end else if (state_q != DETECTED && state_d == DETECTED) begin
            snapshot_q <= snap_d;
        end
    end

    assign bus.snapshot = snapshot_q;
`else
    logic unused_snap;
    assign unused_snap  = |snap_d;
    assign bus.snapshot = '0;
`endif

    assign bus.deadlock     = deadlock_q;
    assign bus.deadlock_src = src_q;
    assign bus.stall_cnt    = cnt_q;
    assign bus.state_dbg    = state_q;
endmodule

// File: tb/tb_mvau_hls_deadlock_report_ctrl.sv
// Directed plus randomized bench for mvau_hls_deadlock_report_ctrl (NUM_MON=4, THRESH=8).
module tb_mvau_hls_deadlock_report_ctrl;
    localparam int NUM_MON = 4;
    localparam int THRESH  = 8;
    localparam int CNT_W   = 16;
    localparam int SRC_W   = 2;

    logic clock = 1'b0;
    logic reset = 1'b1;
    always #5 clock = ~clock;

    mvau_hls_deadlock_report_ctrl_if #(.NUM_MON(NUM_MON), .CNT_W(CNT_W), .SRC_W(SRC_W)) bus ();

    mvau_hls_deadlock_report_ctrl #(
        .NUM_MON(NUM_MON), .THRESH(THRESH), .CNT_W(CNT_W), .SRC_W(SRC_W)
    ) dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus.slave)
    );

    int n_total = 0;
    int n_pass  = 0;
    int n_fail  = 0;

    // Reference model: counts the run of consecutive enabled+blocked edges.
    int unsigned m_run  = 0;
    bit          m_det  = 0;
    int unsigned m_src  = 0;
    int unsigned m_cnt  = 0;
    int unsigned m_snap = 0;

    function automatic int unsigned lowest_bit(input logic [NUM_MON-1:0] v);
        for (int i = 0; i < NUM_MON; i++) if (v[i]) return i;
        return 0;
    endfunction

    task automatic model_edge(input bit rst, input bit clr, input bit en, input logic [NUM_MON-1:0] blk);
        if (rst || clr) begin
            m_run = 0; m_det = 0; m_src = 0; m_cnt = 0; m_snap = 0;
        end else if (!m_det) begin
            if (en && blk != 0) begin
                m_run++;
                if (m_run >= THRESH) begin
                    m_det  = 1;
                    m_cnt  = THRESH;
                    m_src  = lowest_bit(blk);
                    m_snap = blk;
                end else begin
                    m_cnt = m_run;
                end
            end else begin
                m_run = 0;
                m_cnt = 0;
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_total++;
        assert (obs === exp) n_pass++;
        else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string tag);
        int unsigned exp_snap;
`ifdef DEADLOCK_SNAPSHOT_EN
        exp_snap = m_snap;
`else
        exp_snap = 0;
`endif
        check({tag, ".deadlock"}, 32'(bus.deadlock), 32'(m_det));
        check({tag, ".src"},      32'(bus.deadlock_src), m_src);
        check({tag, ".cnt"},      32'(bus.stall_cnt), m_cnt);
        check({tag, ".snapshot"}, 32'(bus.snapshot), exp_snap);
    endtask

    // Drive one edge worth of inputs, advance the model, sample #1 after the edge.
    task automatic step(input string tag, input bit rst, input bit clr, input bit en,
                        input logic [NUM_MON-1:0] blk);
        reset        = rst;
        bus.clear    = clr;
        bus.enable   = en;
        bus.block_in = blk;
        @(posedge clock);
        model_edge(rst, clr, en, blk);
        #1;
        check_all(tag);
    endtask

    function automatic logic [NUM_MON-1:0] rnd_nz();
        return NUM_MON'($urandom_range(1, (1 << NUM_MON) - 1));
    endfunction

    initial begin
        bus.block_in = '0;
        bus.enable   = 1'b0;
        bus.clear    = 1'b0;

        step("reset0", 1, 0, 0, '0);
        step("reset1", 1, 0, 1, 4'b1111);

        // Basic detection, then sticky hold
        for (int i = 0; i < 10; i++) step("basic", 0, 0, 1, 4'b0100);
        step("basic_clr", 0, 1, 1, 4'b0100);

        // Interrupted stall restarts the count
        for (int i = 0; i < 7; i++) step("interrupt_a", 0, 0, 1, rnd_nz());
        step("interrupt_gap", 0, 0, 1, 4'b0000);
        for (int i = 0; i < 8; i++) step("interrupt_b", 0, 0, 1, rnd_nz());
        step("interrupt_clr", 0, 1, 0, '0);

        // Source index and freeze in DETECTED
        for (int i = 0; i < 7; i++) step("src_run", 0, 0, 1, rnd_nz());
        step("src_detect", 0, 0, 1, 4'b1010);
        step("freeze_zero", 0, 0, 1, 4'b0000);
        step("freeze_dis", 0, 0, 0, 4'b0001);
        step("freeze_clr", 0, 1, 1, 4'b0001);

        // Clear beats detection on the same edge, then clear from DETECTED
        step("prio_pre", 0, 0, 0, '0);
        for (int i = 0; i < 7; i++) step("prio_run", 0, 0, 1, rnd_nz());
        step("prio_clr", 0, 1, 1, 4'b0011);
        for (int i = 0; i < 8; i++) step("prio_redo", 0, 0, 1, 4'b1000);
        step("prio_clr_det", 0, 1, 1, 4'b1000);
        step("prio_after", 0, 0, 0, '0);

        // Enable gating
        for (int i = 0; i < 20; i++) step("gate_off", 0, 0, 0, 4'b1111);
        for (int i = 0; i < 8; i++) step("gate_on", 0, 0, 1, 4'b1111);
        step("gate_clr", 0, 1, 0, '0);

        // Reset mid-count and in DETECTED
        for (int i = 0; i < 5; i++) step("rst_cnt", 0, 0, 1, 4'b0110);
        step("rst_mid", 1, 0, 1, 4'b0110);
        for (int i = 0; i < 8; i++) step("rst_redo", 0, 0, 1, 4'b0110);
        step("rst_det", 1, 0, 1, 4'b0110);
        for (int i = 0; i < 3; i++) step("rst_restart", 0, 0, 1, 4'b0110);

        // Randomized traffic with long blocked runs and rare clears
        for (int i = 0; i < 400; i++) begin
            bit en, clr;
            logic [NUM_MON-1:0] blk;
            en  = ($urandom_range(0, 15) != 0);
            clr = ($urandom_range(0, 63) == 0);
            blk = ($urandom_range(0, 11) == 0) ? '0 : NUM_MON'($urandom_range(0, 15));
            step("random", 0, clr, en, blk);
        end

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
